// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit: PC, in-order memory requests, prefetch FIFO, jump redirect
// Credits (outstanding + buffered) bound the FIFO so returned words can never overflow it.
module ifu #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        req_o,
  output logic [31:0] addr_o,
  input  logic        gnt_i,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        ins_ready_i,
  output logic [31:0] ins_o,
  output logic [31:0] ins_addr_o,
  output logic        ins_valid_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e         state_q, state_d;
  logic [31:0]    pc_q, pc_d;
  logic [31:0]    tag_pc_q, tag_pc_d;
  logic [31:0]    last_addr_q, last_addr_d;
  logic [CW-1:0]  out_q, out_d;
  logic [CW-1:0]  discard_q, discard_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [31:0]    fifo_data_q [FIFO_DEPTH];
  logic [31:0]    fifo_addr_q [FIFO_DEPTH];

  logic           resp_valid, resp_push, resp_drop, fifo_pop, issue;
  logic [CW:0]    credit;
  logic [CW-1:0]  out_after;
  logic [31:0]    jump_tgt;

  // A pop this cycle frees a credit immediately, keeping a one-per-cycle stream at latency 1.
  always_comb begin
    resp_valid = rvalid_i && (out_q != '0);
    resp_drop  = resp_valid && (discard_q != '0);
    resp_push  = resp_valid && (discard_q == '0) && !jump_flag_i;
    fifo_pop   = (cnt_q != '0) && ins_ready_i && !jump_flag_i;
    credit     = {1'b0, out_q} + {1'b0, cnt_q} - {{CW{1'b0}}, fifo_pop};
    req_o      = (state_q == FETCH) && !jump_flag_i && (credit < DEPTH_C);
    issue      = req_o && gnt_i;
    addr_o     = pc_q;
    out_after  = out_q + {{(CW-1){1'b0}}, issue} - {{(CW-1){1'b0}}, resp_valid};
    jump_tgt   = jump_addr_i & 32'hFFFF_FFFC;
  end

  always_comb begin
    ins_valid_o = (cnt_q != '0);
    ins_o       = ins_valid_o ? fifo_data_q[rd_ptr_q] : NOP_INST;
    ins_addr_o  = ins_valid_o ? fifo_addr_q[rd_ptr_q] : last_addr_q;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tag_pc_d    = tag_pc_q;
    out_d       = out_after;
    discard_d   = discard_q;
    cnt_d       = cnt_q + {{(CW-1){1'b0}}, resp_push} - {{(CW-1){1'b0}}, fifo_pop};
    wr_ptr_d    = wr_ptr_q + {{(PW-1){1'b0}}, resp_push};
    rd_ptr_d    = rd_ptr_q + {{(PW-1){1'b0}}, fifo_pop};
    last_addr_d = ins_addr_o;

    if (issue)     pc_d      = pc_q + 32'd4;
    if (resp_push) tag_pc_d  = tag_pc_q + 32'd4;
    if (resp_drop) discard_d = discard_q - {{(CW-1){1'b0}}, 1'b1};

    unique case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   state_d = FETCH;
      DRAIN:   if (discard_q == '0) state_d = FETCH;
      default: state_d = IDLE;
    endcase

    // Every response still in flight after this cycle belongs to the old stream.
    if (jump_flag_i) begin
      pc_d      = jump_tgt;
      tag_pc_d  = jump_tgt;
      discard_d = out_after;
      cnt_d     = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      state_d   = (out_after != '0) ? DRAIN : FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_ADDR;
      tag_pc_q    <= RESET_ADDR;
      last_addr_q <= RESET_ADDR;
      out_q       <= '0;
      discard_q   <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= NOP_INST;
        fifo_addr_q[i] <= RESET_ADDR;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tag_pc_q    <= tag_pc_d;
      last_addr_q <= last_addr_d;
      out_q       <= out_d;
      discard_q   <= discard_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      if (resp_push) begin
        fifo_data_q[wr_ptr_q] <= rdata_i;
        fifo_addr_q[wr_ptr_q] <= tag_pc_q;
      end
    end
  end

endmodule
